// File: rtl/hazard_ctrl_pkg.sv
// Shared types and default parameters for the ID-stage hazard controller.
// The state encoding is fixed at two bits.
package hazard_pkg;

   localparam int REG_AW_DEF      = 5;
   localparam int MEM_TIMEOUT_DEF = 64;
   localparam int CNT_W_DEF       = 16;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_BUBBLE  = 2'd1,
      ST_MEMWAIT = 2'd2
   } hz_state_t;

   // Saturating increment used by the stall-cycle counter.
   function automatic logic [CNT_W_DEF-1:0] sat_inc16(input logic [CNT_W_DEF-1:0] v);
      if (&v) begin
         sat_inc16 = v;
      end else begin
         sat_inc16 = v + {{(CNT_W_DEF-1){1'b0}}, 1'b1};
      end
   endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use compare: a load in EX whose destination is a source
// of the instruction in ID. Register $0 never creates a dependence.
module load_use_detect
   import hazard_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] i_ifid_rs,
   input  logic [REG_AW-1:0] i_ifid_rt,
   input  logic              i_ifid_uses_rt,
   input  logic              i_idex_memread,
   input  logic [REG_AW-1:0] i_idex_rt,
   output logic              o_luh
);

   logic w_dst_nonzero;
   logic w_rs_match;
   logic w_rt_match;

   assign w_dst_nonzero = (i_idex_rt != {REG_AW{1'b0}});
   assign w_rs_match    = (i_idex_rt == i_ifid_rs);
   assign w_rt_match    = i_ifid_uses_rt && (i_idex_rt == i_ifid_rt);
   assign o_luh         = i_idex_memread && w_dst_nonzero && (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubble, branch
// flush, and memory-wait freeze with timeout, plus a saturating stall counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW      = REG_AW_DEF,
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] IFID_RsAddr_i,
   input  logic [REG_AW-1:0] IFID_RtAddr_i,
   input  logic              IFID_UsesRt_i,
   input  logic              IDEX_MemRead_i,
   input  logic [REG_AW-1:0] IDEX_RtAddr_i,
   input  logic              Branch_i,
   input  logic              Jump_i,
   input  logic              DmemReq_i,
   input  logic              DmemAck_i,
   output logic              PCWrite_o,
   output logic              IFIDWrite_o,
   output logic              IFIDFlush_o,
   output logic              IDEXBubble_o,
   output logic              Freeze_o,
   output logic              Err_o,
   output logic [CNT_W-1:0]  StallCnt_o
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   hz_state_t         r_state;
   hz_state_t         w_next_state;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_err;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_luh;
   logic w_memstall;
   logic w_redirect;
   logic w_pc_write;
   logic w_ifid_write;
   logic w_flush;
   logic w_bubble;
   logic w_freeze;
   logic w_timeout;

   load_use_detect #(
      .REG_AW(REG_AW)
   ) u_luh (
      .i_ifid_rs      (IFID_RsAddr_i),
      .i_ifid_rt      (IFID_RtAddr_i),
      .i_ifid_uses_rt (IFID_UsesRt_i),
      .i_idex_memread (IDEX_MemRead_i),
      .i_idex_rt      (IDEX_RtAddr_i),
      .o_luh          (w_luh)
   );

   assign w_memstall = DmemReq_i && !DmemAck_i;
   assign w_redirect = Branch_i || Jump_i;

   // Next-state and hazard outputs; default is a plain pipeline advance.
   always_comb begin
      w_next_state = ST_RUN;
      w_pc_write   = 1'b1;
      w_ifid_write = 1'b1;
      w_flush      = 1'b0;
      w_bubble     = 1'b0;
      w_freeze     = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         ST_RUN, ST_BUBBLE: begin
            if (w_memstall) begin
               w_freeze     = 1'b1;
               w_pc_write   = 1'b0;
               w_ifid_write = 1'b0;
               w_next_state = ST_MEMWAIT;
            end else if (w_luh && (r_state == ST_RUN)) begin
               // A branch resolved this cycle used the stale register; drop it.
               w_pc_write   = 1'b0;
               w_ifid_write = 1'b0;
               w_bubble     = 1'b1;
               w_next_state = ST_BUBBLE;
            end else begin
               w_flush      = w_redirect;
               w_next_state = ST_RUN;
            end
         end
         ST_MEMWAIT: begin
            if (!DmemAck_i) begin
               w_freeze     = 1'b1;
               w_pc_write   = 1'b0;
               w_ifid_write = 1'b0;
               if (r_wait_cnt == WAIT_LAST) begin
                  w_timeout    = 1'b1;
                  w_next_state = ST_RUN;
               end else begin
                  w_next_state = ST_MEMWAIT;
               end
            end else if (w_luh) begin
               w_pc_write   = 1'b0;
               w_ifid_write = 1'b0;
               w_bubble     = 1'b1;
               w_next_state = ST_BUBBLE;
            end else begin
               w_flush      = w_redirect;
               w_next_state = ST_RUN;
            end
         end
         default: begin
            w_next_state = ST_RUN;
         end
      endcase
   end

   // Outputs are held inactive for as long as reset is asserted.
   assign PCWrite_o    = w_pc_write   && rst_i;
   assign IFIDWrite_o  = w_ifid_write && rst_i;
   assign IFIDFlush_o  = w_flush      && rst_i;
   assign IDEXBubble_o = w_bubble     && rst_i;
   assign Freeze_o     = w_freeze     && rst_i;
   assign Err_o        = r_err;
   assign StallCnt_o   = r_stall_cnt;

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Memory wait counter: counts unacknowledged MEMWAIT cycles, cleared otherwise.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wait_cnt <= {WAIT_W{1'b0}};
      end else if ((r_state == ST_MEMWAIT) && (w_next_state == ST_MEMWAIT)) begin
         r_wait_cnt <= r_wait_cnt + WAIT_ONE;
      end else begin
         r_wait_cnt <= {WAIT_W{1'b0}};
      end
   end

   // Sticky timeout flag; only reset clears it.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_err <= 1'b0;
      end else if (w_timeout) begin
         r_err <= 1'b1;
      end else begin
         r_err <= r_err;
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_stall_cnt <= {CNT_W{1'b0}};
      end else if (!PCWrite_o && !(&r_stall_cnt)) begin
         r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

endmodule
